addsub_accumulator: RTL and testbench



---
 rtl/addsub_accumulator.sv | 93 +++++++++
 tb/tb_addsub_accumulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accumulator.sv
// Accumulator stage over an N-bit ripple-carry adder/subtractor: one operand per
// two-cycle IDLE/EXEC handshake, with registered result, carry, overflow and op count.
module addsub_accumulator #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  b,
    input  logic          ctrl,
    output logic [N-1:0]  acc,
    output logic          cout,
    output logic          ovf,
    output logic          out_valid,
    output logic [CW-1:0] op_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_b;
    logic          r_ctrl;
    logic [N-1:0]  r_acc;
    logic          r_cout;
    logic          r_ovf;
    logic          r_out_valid;
    logic [CW-1:0] r_op_count;

    logic [N-1:0]  w_bx;
    logic [N-1:0]  w_sum;
    logic [N:0]    w_carry;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // Subtraction reuses the adder: invert the operand and inject ctrl as carry-in.
    always_comb begin
        w_bx       = r_b ^ {N{r_ctrl}};
        w_sum      = '0;
        w_carry    = '0;
        w_carry[0] = r_ctrl;
        for (int i = 0; i < N; i++) begin
            w_sum[i]       = r_acc[i] ^ w_bx[i] ^ w_carry[i];
            w_carry[i + 1] = (r_acc[i] & w_bx[i]) | (w_carry[i] & (r_acc[i] ^ w_bx[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_b     <= b;
                        r_ctrl  <= ctrl;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc       <= w_sum;
                    r_cout      <= w_carry[N];
                    r_ovf       <= w_carry[N] ^ w_carry[N-1];
                    r_out_valid <= 1'b1;
                    r_op_count  <= sat_inc(r_op_count);
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign acc       = r_acc;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed and randomized bench for addsub_accumulator against an integer-arithmetic model.
module tb_addsub_accumulator;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  b;
    logic          ctrl;
    logic [N-1:0]  acc;
    logic          cout;
    logic          ovf;
    logic          out_valid;
    logic [CW-1:0] op_count;

    int total = 0;
    int bad   = 0;

    int m_acc;
    int m_cnt;
    int m_cout;
    int m_ovf;

    addsub_accumulator #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .b        (b),
        .ctrl     (ctrl),
        .acc      (acc),
        .cout     (cout),
        .ovf      (ovf),
        .out_valid(out_valid),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_cout = 0;
        m_ovf  = 0;
        m_cnt  = 0;
    endtask

    // Unsigned result for acc/cout, signed integer result for overflow.
    task automatic model_apply(input int bv, input int c);
        int full;
        int half;
        int ur;
        int sa;
        int sb;
        int sr;
        full = 1 << N;
        half = 1 << (N - 1);
        sa   = (m_acc >= half) ? m_acc - full : m_acc;
        sb   = (bv >= half) ? bv - full : bv;
        if (c != 0) begin
            ur     = m_acc - bv;
            m_cout = (m_acc >= bv) ? 1 : 0;
            sr     = sa - sb;
        end else begin
            ur     = m_acc + bv;
            m_cout = (ur >= full) ? 1 : 0;
            sr     = sa + sb;
        end
        m_acc = ((ur % full) + full) % full;
        m_ovf = (sr < -half || sr > half - 1) ? 1 : 0;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
        chk({tag, "_cout"}, 32'(cout), 32'(m_cout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, "_cnt"}, 32'(op_count), 32'(m_cnt));
    endtask

    // Accept, execute (scrambling b/ctrl mid-flight), then confirm the valid pulse drops.
    task automatic op(input logic [N-1:0] bv, input logic c);
        chk("rdy_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        b        = bv;
        ctrl     = c;
        step();
        chk("rdy_exec", 32'(in_ready), 32'd0);
        chk("vld_exec", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        b        = N'($urandom);
        ctrl     = 1'($urandom);
        step();
        model_apply(int'(bv), int'(c));
        chk("vld_pulse", 32'(out_valid), 32'd1);
        check_state("op");
        step();
        chk("vld_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [N-1:0] pb;
        logic         pc;
        logic [N-1:0] hv;
        logic         hc;

        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        b        = '0;
        ctrl     = 1'b0;
        pb       = '0;
        pc       = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        check_state("reset");
        chk("reset_rdy", 32'(in_ready), 32'd1);
        chk("reset_vld", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_vld", 32'(out_valid), 32'd0);
        end

        op(4'hB, 1'b0);
        chk("add1_acc", 32'(acc), 32'hB);
        chk("add1_cout", 32'(cout), 32'd0);
        op(4'h6, 1'b0);
        chk("add2_acc", 32'(acc), 32'h1);
        chk("add2_cout", 32'(cout), 32'd1);
        chk("add2_ovf", 32'(ovf), 32'd0);
        chk("add2_cnt", 32'(op_count), 32'd2);

        op(4'h3, 1'b1);
        chk("sub1_acc", 32'(acc), 32'hE);
        chk("sub1_cout", 32'(cout), 32'd0);
        op(4'h4, 1'b1);
        chk("sub2_acc", 32'(acc), 32'hA);
        chk("sub2_cout", 32'(cout), 32'd1);
        chk("sub2_ovf", 32'(ovf), 32'd0);

        clr      = 1'b1;
        in_valid = 1'b1;
        b        = 4'h5;
        step();
        model_reset();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clrv_rdy", 32'(in_ready), 32'd1);
        check_state("clrv");
        step();
        chk("clrv_vld", 32'(out_valid), 32'd0);
        chk("clrv_acc", 32'(acc), 32'd0);

        op(4'h7, 1'b0);
        op(4'h1, 1'b0);
        chk("ovf1_acc", 32'(acc), 32'h8);
        chk("ovf1_cout", 32'(cout), 32'd0);
        chk("ovf1_ovf", 32'(ovf), 32'd1);
        op(4'h1, 1'b1);
        chk("ovf2_acc", 32'(acc), 32'h7);
        chk("ovf2_cout", 32'(cout), 32'd1);
        chk("ovf2_ovf", 32'(ovf), 32'd1);
        op(4'h0, 1'b0);
        chk("ovf3_ovf", 32'(ovf), 32'd0);

        for (int k = 0; k < 8; k++) begin
            hv       = N'($urandom);
            hc       = 1'($urandom);
            in_valid = 1'b1;
            b        = hv;
            ctrl     = hc;
            if (k % 2 == 0) begin
                pb = hv;
                pc = hc;
                step();
                chk("hold_rdy_exec", 32'(in_ready), 32'd0);
            end else begin
                step();
                model_apply(int'(pb), int'(pc));
                chk("hold_vld", 32'(out_valid), 32'd1);
                chk("hold_rdy_idle", 32'(in_ready), 32'd1);
                check_state("hold");
            end
        end
        in_valid = 1'b0;
        step();
        chk("hold_drop", 32'(out_valid), 32'd0);

        for (int r = 0; r < 2; r++) begin
            op(4'h3, 1'b0);
            in_valid = 1'b1;
            b        = 4'h5;
            ctrl     = 1'b0;
            step();
            in_valid = 1'b0;
            if (r == 0) clr = 1'b1;
            else rst = 1'b1;
            step();
            clr = 1'b0;
            rst = 1'b0;
            model_reset();
            chk("abort_vld", 32'(out_valid), 32'd0);
            chk("abort_rdy", 32'(in_ready), 32'd1);
            check_state("abort");
            step();
            chk("abort_vld2", 32'(out_valid), 32'd0);
            chk("abort_acc2", 32'(acc), 32'd0);
        end

        for (int n = 0; n < 270; n++) begin
            op(N'($urandom), 1'($urandom));
            if ($urandom_range(0, 15) == 0) step();
        end
        chk("cnt_sat", 32'(op_count), 32'((1 << CW) - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
